ifu_fetch: RTL

- Multi-cycle instruction fetch unit directly upstream of the decode stage; replaces the zero-latency combinational instruction ROM lookup.
- Holds the architectural PC, issues one fetch at a time over a valid/ready request channel to instruction memory, and captures the response.
- Presents {inst, inst_pc} to decode with a valid/ready handshake.
- Accepts the next PC from the execute/writeback logic once the current instruction retires.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fetch.sv | 98 +++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    NPC  = 3'd4
  } state_t;

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: holds the PC, fetches over a
// valid/ready memory channel and hands {inst, inst_pc} to decode.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = ifu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ifu_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault,
  input  logic            next_pc_valid,
  input  logic [XLEN-1:0] next_pc
);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic [XLEN-1:0] inst_nx, inst_pc_nx;
  logic            fault_nx;
  logic            redirect;
  logic            misaligned;

  // Handshake outputs come from the state register only.
  assign imem_req_valid = (state == REQ);
  assign inst_valid     = (state == HOLD);
  assign imem_req_addr  = pc;
  assign misaligned     = |next_pc[1:0];

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    inst_nx    = inst;
    inst_pc_nx = inst_pc;
    fault_nx   = fetch_fault;
    redirect   = 1'b0;
    case (state)
      BOOT: state_nx = REQ;
      REQ:  if (imem_req_ready) state_nx = WAIT;
      WAIT: begin
        // Responses are only honoured here, which drops stale ones after reset.
        if (imem_rsp_valid) begin
          inst_nx    = imem_rsp_data;
          inst_pc_nx = pc;
          fault_nx   = imem_rsp_err;
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          if (next_pc_valid) redirect = 1'b1;
          else               state_nx = NPC;
        end
      end
      NPC:     redirect = next_pc_valid;
      default: state_nx = BOOT;
    endcase

    // A misaligned target never reaches memory; it is reported as a faulting slot.
    if (redirect) begin
      pc_nx = next_pc;
      if (misaligned) begin
        inst_nx    = '0;
        inst_pc_nx = next_pc;
        fault_nx   = 1'b1;
        state_nx   = HOLD;
      end else begin
        state_nx = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inst        <= '0;
      inst_pc     <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      inst        <= inst_nx;
      inst_pc     <= inst_pc_nx;
      fetch_fault <= fault_nx;
    end
  end

endmodule
